// File: rtl/ula_if.sv
// ============================================================================
// ula_if : operand/result bundle between the datapath and the ALU
// Rev 1.0
// ============================================================================
`default_nettype none

interface ula_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ALUControl;
  logic        FlagWrite;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic [3:0]  StoredFlags;

  modport master (
    output A, B, ALUControl, FlagWrite,
    input  Result, Flags, StoredFlags
  );

  modport slave (
    input  A, B, ALUControl, FlagWrite,
    output Result, Flags, StoredFlags
  );
endinterface

`default_nettype wire

// File: rtl/ula.sv
// ============================================================================
// ula : 32-bit ADD/SUB/AND/ORR unit with NZCV flags and a stored-flag register
// Rev 1.0
// ============================================================================
`default_nettype none

module ula (
  input  wire logic clk,
  input  wire logic reset,
  ula_if.slave      bus
);

  localparam logic [1:0] c_OP_AND = 2'b10;
  localparam logic [1:0] c_OP_ORR = 2'b11;

  logic [31:0] w_b_operand;
  logic [32:0] w_sum;
  logic [31:0] w_result;
  logic        w_n;
  logic        w_z;
  logic        w_c;
  logic        w_v;
  logic [3:0]  w_flags;
  logic [3:0]  r_stored_flags;

  // One adder serves both ADD and SUB; SUB is A + ~B + 1.
  assign w_b_operand = bus.ALUControl[0] ? ~bus.B : bus.B;
  assign w_sum       = {1'b0, bus.A} + {1'b0, w_b_operand} + {32'd0, bus.ALUControl[0]};

  always_comb begin
    w_result = w_sum[31:0];
    case (bus.ALUControl)
      c_OP_AND: w_result = bus.A & bus.B;
      c_OP_ORR: w_result = bus.A | bus.B;
      default:  w_result = w_sum[31:0];
    endcase
  end

  assign w_n = w_result[31];
  assign w_z = (w_result == 32'h0);
  assign w_c = ~bus.ALUControl[1] & w_sum[32];
  // Overflow when operand signs (B inverted for SUB) agree but the sum sign differs from A.
  assign w_v = ~bus.ALUControl[1]
             & ~(bus.A[31] ^ bus.B[31] ^ bus.ALUControl[0])
             & (bus.A[31] ^ w_sum[31]);

  assign w_flags = {w_n, w_z, w_c, w_v};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stored_flags <= 4'b0000;
    end else if (bus.FlagWrite) begin
      r_stored_flags <= w_flags;
    end
  end

  assign bus.Result      = w_result;
  assign bus.Flags       = w_flags;
  assign bus.StoredFlags = r_stored_flags;

endmodule

`default_nettype wire

// File: tb/tb_ula.sv
// ============================================================================
// tb_ula : directed and randomized checks of ula against an arithmetic model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ula;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  ula_if bus ();

  ula dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: flags derived from integer arithmetic, not from adder bits.
  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] res;
    logic [63:0] u;
    longint      sa;
    longint      sb;
    longint      s;
    logic        c;
    logic        v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: begin
        u   = {32'd0, a} + {32'd0, b};
        res = u[31:0];
        c   = (u > 64'hFFFF_FFFF);
        s   = sa + sb;
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'b01: begin
        res = a - b;
        c   = (a >= b);
        s   = sa - sb;
        v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'b10:   res = a & b;
      default: res = a | b;
    endcase
    return {res[31], (res == 32'd0), c, v, res};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fw);
    @(posedge clk);
    #1;
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    bus.FlagWrite  = fw;
  endtask

  task automatic directed(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags);
    apply(op, a, b, 1'b0);
    @(negedge clk);
    check({tag, "_result"}, bus.Result, exp_res);
    check({tag, "_flags"}, {28'd0, bus.Flags}, {28'd0, exp_flags});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [35:0] exp_v;
    logic [3:0]  exp_stored;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        fw;
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.A          = 32'd0;
    bus.B          = 32'd0;
    bus.ALUControl = 2'b00;
    bus.FlagWrite  = 1'b0;
    #2;
    check("reset_stored", {28'd0, bus.StoredFlags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    directed("add_carry_zero", 2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'h6);
    directed("add_overflow",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'h9);
    directed("sub_equal",      2'b01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'h6);
    directed("sub_borrow",     2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'h8);
    directed("sub_overflow",   2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'h3);
    directed("and_zero",       2'b10, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'h4);
    directed("orr_neg",        2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'h8);
    directed("orr_large",      2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8);

    // Stored-flag register sequence.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("sf_reset_pulse", {28'd0, bus.StoredFlags}, 32'd0);
    reset = 1'b0;
    apply(2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("sf_not_yet", {28'd0, bus.StoredFlags}, 32'd0);
    apply(2'b11, 32'h8000_0000, 32'h0000_0001, 1'b0);
    @(negedge clk);
    check("sf_captured", {28'd0, bus.StoredFlags}, 32'h6);
    apply(2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0);
    @(negedge clk);
    check("sf_hold", {28'd0, bus.StoredFlags}, 32'h6);
    reset = 1'b1;
    #1;
    check("sf_async_clear", {28'd0, bus.StoredFlags}, 32'd0);
    check("result_during_reset", bus.Result, 32'hFFFF_FFFF);
    bus.FlagWrite = 1'b1;
    @(posedge clk);
    #1;
    check("sf_reset_wins", {28'd0, bus.StoredFlags}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("sf_first_capture", {28'd0, bus.StoredFlags}, 32'h8);

    // Randomized sweep; stored flags tracked from the model's own flag history.
    exp_stored = 4'h8;
    for (int i = 0; i < 10000; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      fw = 1'($urandom_range(0, 1));
      apply(op, a, b, fw);
      exp_v = model(op, a, b);
      @(negedge clk);
      n_cmp++;
      assert ({bus.Flags, bus.Result} === exp_v)
      else begin
        n_err++;
        $error("FAIL rand_%0d op=%0d a=%08h b=%08h: got %h_%08h expected %h_%08h", i, op, a,
               b, bus.Flags, bus.Result, exp_v[35:32], exp_v[31:0]);
      end
      check("rand_stored", {28'd0, bus.StoredFlags}, {28'd0, exp_stored});
      if (fw) exp_stored = exp_v[35:32];
    end
    @(posedge clk);
    #1;
    check("rand_stored_final", {28'd0, bus.StoredFlags}, {28'd0, exp_stored});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
